// File: rtl/cpu_types_pkg.sv
// Shared CPU types plus the register scoreboard's depth and counter type.
package cpu_types_pkg;

  // Architectural register select.
  typedef logic [4:0] regbits_t;

  // Scoreboard depth: maximum outstanding register writes in flight.
  localparam int SB_DEPTH = 3;
  localparam int SB_CW    = $clog2(SB_DEPTH + 1);

  // Per-register and total outstanding-write counter.
  typedef logic [SB_CW-1:0] sbcnt_t;

  // Saturation ceiling expressed in counter width.
  localparam sbcnt_t SB_MAX = sbcnt_t'(SB_DEPTH);

  // True when a register select names a tracked register (anything but r0).
  function automatic logic reg_is_tracked(input regbits_t r);
    return (r != 5'd0);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: saturating up/down counter of pending writes to a register.
module sb_entry
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   i_inc,
  input  logic   i_dec,
  input  logic   i_clr,
  output sbcnt_t o_cnt,
  output logic   o_busy
);

  sbcnt_t r_cnt;

  // Count issued-but-unretired writes; inc and dec together cancel, clr wins over both.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != SB_MAX)) begin
      r_cnt <= r_cnt + sbcnt_t'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - sbcnt_t'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/rf_scoreboard.sv
// Decode-stage register scoreboard: tracks pending writes per register,
// stalls issue on RAW hazards or a full window, retires on register-file writes.
module rf_scoreboard
  import cpu_types_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        issue_valid,
  input  regbits_t    rs,
  input  regbits_t    rt,
  input  logic        rs_used,
  input  logic        rt_used,
  input  regbits_t    rd,
  input  logic        rd_wen,
  output logic        issue_ready,
  input  logic        wb_wen,
  input  regbits_t    wb_sel,
  input  logic        flush,
  output logic [31:0] busy,
  output sbcnt_t      inflight,
  output logic        underflow
);

  sbcnt_t      r_inflight;
  logic        r_underflow;
  sbcnt_t      w_cnt [32];
  logic [31:0] w_busy;
  logic        w_raw;
  logic        w_full;
  logic        w_ready;
  logic        w_inc_any;
  logic        w_ret_req;
  logic        w_ret_ok;
  logic        w_ret_bad;

  // Register 0 is never tracked.
  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  // Hazard detection and issue/retire qualification from registered state.
  always_comb begin
    w_raw     = (rs_used && reg_is_tracked(rs) && w_busy[rs]) ||
                (rt_used && reg_is_tracked(rt) && w_busy[rt]);
    w_full    = rd_wen && reg_is_tracked(rd) && (r_inflight == SB_MAX);
    w_ready   = !(w_raw || w_full);
    w_inc_any = issue_valid && w_ready && rd_wen && reg_is_tracked(rd) && !flush;
    w_ret_req = wb_wen && reg_is_tracked(wb_sel) && !flush;
    w_ret_ok  = w_ret_req && (w_cnt[wb_sel] != '0);
    w_ret_bad = w_ret_req && (w_cnt[wb_sel] == '0);
  end

  genvar g;
  generate
    for (g = 1; g < 32; g++) begin : g_entry
      logic w_inc;
      logic w_dec;
      assign w_inc = w_inc_any && (rd == regbits_t'(g));
      assign w_dec = w_ret_ok && (wb_sel == regbits_t'(g));
      sb_entry u_entry (
        .CLK    (CLK),
        .nRST   (nRST),
        .i_inc  (w_inc),
        .i_dec  (w_dec),
        .i_clr  (flush),
        .o_cnt  (w_cnt[g]),
        .o_busy (w_busy[g])
      );
    end
  endgenerate

  // Total outstanding writes; a same-cycle issue and retire cancel out.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_inflight <= '0;
    end else if (flush) begin
      r_inflight <= '0;
    end else begin
      case ({w_inc_any, w_ret_ok})
        2'b10:   r_inflight <= r_inflight + sbcnt_t'(1);
        2'b01:   r_inflight <= r_inflight - sbcnt_t'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Sticky error: a retire arrived for a register with nothing outstanding.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_underflow <= 1'b0;
    end else if (w_ret_bad) begin
      r_underflow <= 1'b1;
    end else begin
      r_underflow <= r_underflow;
    end
  end

  assign issue_ready = w_ready;
  assign busy        = w_busy;
  assign inflight    = r_inflight;
  assign underflow   = r_underflow;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Self-checking bench for rf_scoreboard: directed test-plan steps followed by
// randomized traffic, all checked against a per-register count model.
module tb_rf_scoreboard;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        issue_valid;
  regbits_t    rs, rt, rd, wb_sel;
  logic        rs_used, rt_used, rd_wen, wb_wen, flush;
  logic        issue_ready;
  logic [31:0] busy;
  sbcnt_t      inflight;
  logic        underflow;

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding writes per register, total and error flag.
  int m_cnt [32];
  int m_infl;
  bit m_under;
  logic last_rdy;

  rf_scoreboard dut (
    .CLK(CLK), .nRST(nRST), .issue_valid(issue_valid),
    .rs(rs), .rt(rt), .rs_used(rs_used), .rt_used(rt_used),
    .rd(rd), .rd_wen(rd_wen), .issue_ready(issue_ready),
    .wb_wen(wb_wen), .wb_sel(wb_sel), .flush(flush),
    .busy(busy), .inflight(inflight), .underflow(underflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_cnt[i] = 0;
    m_infl = 0;
  endtask

  function automatic logic model_ready();
    bit raw, full;
    raw  = (rs_used && rs != 0 && m_cnt[rs] > 0) || (rt_used && rt != 0 && m_cnt[rt] > 0);
    full = rd_wen && rd != 0 && m_infl >= SB_DEPTH;
    return !(raw || full);
  endfunction

  task automatic model_update(input logic rdy);
    if (flush) begin
      model_clear();
    end else begin
      if (issue_valid && rdy && rd_wen && rd != 0) begin
        m_cnt[rd]++;
        m_infl++;
      end
      if (wb_wen && wb_sel != 0) begin
        // Decide against the count as it stood before this edge's issue.
        if (m_cnt[wb_sel] - ((issue_valid && rdy && rd_wen && rd == wb_sel) ? 1 : 0) == 0) begin
          m_under = 1'b1;
        end else begin
          m_cnt[wb_sel]--;
          m_infl--;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_busy();
    logic [31:0] b;
    b = 32'd0;
    for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] > 0);
    return b;
  endfunction

  task automatic set_in(input logic iv, input int rs_, input logic ru, input int rt_,
                        input logic tu, input int rd_, input logic dw,
                        input logic ww, input int ws, input logic fl);
    issue_valid = iv; rs = regbits_t'(rs_); rs_used = ru; rt = regbits_t'(rt_);
    rt_used = tu; rd = regbits_t'(rd_); rd_wen = dw; wb_wen = ww;
    wb_sel = regbits_t'(ws); flush = fl;
  endtask

  // One clock: check ready before the edge, advance the model, check state after.
  task automatic step(input string tag);
    logic exp_rdy;
    #1;
    exp_rdy  = model_ready();
    last_rdy = issue_ready;
    chk({tag, ":ready"}, {31'd0, issue_ready}, {31'd0, exp_rdy});
    @(posedge CLK);
    model_update(exp_rdy);
    #1;
    chk({tag, ":busy"}, busy, model_busy());
    chk({tag, ":inflight"}, {30'd0, inflight}, 32'(m_infl));
    chk({tag, ":underflow"}, {31'd0, underflow}, {31'd0, m_under});
    @(negedge CLK);
  endtask

  initial begin
    int q [$];
    nRST = 1'b0;
    m_under = 1'b0;
    model_clear();
    // Reset holds with arbitrary inputs: ready must still be 1.
    set_in(1'b1, 5, 1'b1, 6, 1'b1, 7, 1'b1, 1'b0, 0, 1'b0);
    #3;
    chk("reset:ready", {31'd0, issue_ready}, 32'd1);
    chk("reset:busy", busy, 32'd0);
    chk("reset:inflight", {30'd0, inflight}, 32'd0);
    chk("reset:underflow", {31'd0, underflow}, 32'd0);
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge CLK);
    nRST = 1'b1;
    step("t1_idle");
    chk("t1:ready", {31'd0, last_rdy}, 32'd1);

    // RAW stall: issue rd=5, dependents stall until the retire edge has passed.
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 0, 1'b0); step("t2_c0");
    set_in(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0); step("t2_c1");
    chk("t2:stall_c1", {31'd0, last_rdy}, 32'd0);
    step("t2_c2");
    chk("t2:stall_c2", {31'd0, last_rdy}, 32'd0);
    set_in(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1'b0); step("t2_c3");
    chk("t2:stall_c3", {31'd0, last_rdy}, 32'd0);
    set_in(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0); step("t2_c4");
    chk("t2:ready_c4", {31'd0, last_rdy}, 32'd1);

    // Register 0 is never tracked.
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0); step("t3_wr0");
    set_in(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 0, 1'b0); step("t3_rd0");
    chk("t3:ready", {31'd0, last_rdy}, 32'd1);
    chk("t3:inflight", {30'd0, inflight}, 32'd0);
    chk("t3:underflow", {31'd0, underflow}, 32'd0);

    // Capacity and simultaneous events.
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0); step("t4_i1");
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0); step("t4_i2");
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0); step("t4_i3");
    chk("t4:inflight3", {30'd0, inflight}, 32'd3);
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b0); step("t4_full");
    chk("t4:full", {31'd0, last_rdy}, 32'd0);
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b1, 1, 1'b0); step("t4_ret_iss");
    chk("t4:still_full", {31'd0, last_rdy}, 32'd0);
    chk("t4:inflight2", {30'd0, inflight}, 32'd2);
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1, 1'b0, 0, 1'b0); step("t4_accept");
    chk("t4:accept", {31'd0, last_rdy}, 32'd1);
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0); step("t4_ret3");
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b1, 2, 1'b0); step("t4_same");
    chk("t4:busy2", {31'd0, busy[2]}, 32'd1);
    chk("t4:inflight_same", {30'd0, inflight}, 32'd2);

    // WAW and flush.
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1); step("t5_flush0");
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b0, 0, 1'b0); step("t5_w7a");
    step("t5_w7b");
    chk("t5:inflight2", {30'd0, inflight}, 32'd2);
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 7, 1'b0); step("t5_ret7");
    chk("t5:busy7", {31'd0, busy[7]}, 32'd1);
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b0, 0, 1'b1); step("t5_flush");
    chk("t5:busy0", busy, 32'd0);
    chk("t5:inflight0", {30'd0, inflight}, 32'd0);

    // Underflow is sticky until reset.
    set_in(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 12, 1'b0); step("t6_under");
    chk("t6:under_set", {31'd0, underflow}, 32'd1);
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b1); step("t6_hold");
    chk("t6:under_hold", {31'd0, underflow}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    m_under = 1'b0;
    model_clear();
    chk("t6:under_clr", {31'd0, underflow}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    set_in(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b0, 0, 1'b0); step("t6_post");
    chk("t6:busy6", {31'd0, busy[6]}, 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      int ws;
      q.delete();
      for (int i = 1; i < 32; i++) if (m_cnt[i] > 0) q.push_back(i);
      if (q.size() > 0 && $urandom_range(9) < 8) ws = q[$urandom_range(q.size() - 1)];
      else ws = $urandom_range(31);
      set_in(1'($urandom_range(1)), $urandom_range(15), 1'($urandom_range(1)),
             $urandom_range(15), 1'($urandom_range(1)), $urandom_range(15),
             1'($urandom_range(1)), ($urandom_range(2) == 0), ws,
             ($urandom_range(49) == 0));
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
